// File: rtl/ung_pkg.sv
// ung_pkg
// Shared types and helpers for the parallel unary (thermometer) stream
// generator.
//   ung_state_e      : IDLE / RUN
//   ung_clog2()      : ceiling log2, elaboration-time
//   ung_len()        : stream length L = 2^W
//   ung_beats()      : beats per stream L/P
//   UNG_ASSERT_POW2_P: elaboration check that P is a power of two in [1, 2^W]
package ung_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ung_state_e;

    function automatic int ung_clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int ung_len(input int w);
        return 1 << w;
    endfunction

    function automatic int ung_beats(input int w, input int p);
        return (1 << w) / p;
    endfunction

endpackage

`define UNG_ASSERT_POW2_P(p_, w_) \
    if (((p_) < 1) || ((p_) > (1 << (w_))) || ((((p_) & ((p_) - 1))) != 0)) begin : g_bad_p \
        $error("ung_par_stream: P must be a power of two with 1 <= P <= 2^W"); \
    end

// File: rtl/ung_thermo_dec.sv
// ung_thermo_dec
// Combinational saturating thermometer decoder.
//   cnt   [W:0]   : count of bits to set
//   therm [P-1:0] : therm[j] = (cnt > j); all ones once cnt >= P
module ung_thermo_dec
    import ung_pkg::*;
#(
    parameter int W = 8,
    parameter int P = 4
) (
    input  logic [W:0]   cnt,
    output logic [P-1:0] therm
);

    always_comb begin
        therm = '0;
        for (int j = 0; j < P; j++) begin
            therm[j] = (cnt > (W+1)'(j));
        end
    end

endmodule

// File: rtl/ung_par_stream.sv
// ung_par_stream
// Parallel unary bit-stream generator. One W-bit value N is accepted per
// transaction; a stream of L = 2^W bits is emitted P bits per beat over L/P
// beats, with exactly N ones.
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : in_data valid
//   in_ready   : value can be accepted (idle, or on the last-beat transfer)
//   in_data    : N, unsigned
//   in_trail   : (UNG_TRAIL_EN only) place the ones at the end of the stream
//   out_valid  : beat valid
//   out_ready  : downstream accepts the beat
//   out_data   : beat bits, bit 0 earliest in time
//   out_last   : final beat of the stream
// Build option: define UNG_TRAIL_EN to add in_trail and trailing-ones mode.
//
// state | meaning
// IDLE  | no stream in flight, waiting for in_valid
// RUN   | emitting beats of the current stream
module ung_par_stream
    import ung_pkg::*;
#(
    parameter int W = 8,
    parameter int P = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
`ifdef UNG_TRAIL_EN
    input  logic         in_trail,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [P-1:0] out_data,
    output logic         out_last
);

    localparam int L     = ung_len(W);
    localparam int BEATS = ung_beats(W, P);
    localparam int LOGP  = ung_clog2(P);
    // A single-beat stream (P = L) still needs a 1-bit index to stay legal.
    localparam int BW    = (W > LOGP) ? (W - LOGP) : 1;

    localparam logic [W:0]    P_CNT     = (W+1)'(P);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    generate
        `UNG_ASSERT_POW2_P(P, W)
    endgenerate

    ung_state_e    state;
    logic [W:0]    rem;
    logic [BW-1:0] beat;
    logic [W:0]    rem_step;
    logic [W:0]    dec_cnt;
    logic [P-1:0]  dec_therm;
    logic          accept;
    logic          xfer;
    logic          is_run;

    assign is_run    = (state == RUN);
    assign out_valid = is_run;
    assign out_last  = is_run && (beat == LAST_BEAT);
    assign xfer      = is_run && out_ready;
    assign in_ready  = !is_run || (out_last && out_ready);
    assign accept    = in_valid && in_ready;

    // min(rem, P): the remaining count saturates at zero instead of wrapping.
    assign rem_step = (rem > P_CNT) ? P_CNT : rem;

`ifdef UNG_TRAIL_EN
    // Trailing mode counts down the L-N leading zeros first. Once those are
    // exhausted every remaining bit is a one, so the beat is simply the
    // inverted thermometer of the zero count.
    localparam logic [W:0] L_CNT = (W+1)'(L);

    logic       trail_q;
    logic [W:0] rem_zero;
    logic [W:0] zero_step;

    assign zero_step = (rem_zero > P_CNT) ? P_CNT : rem_zero;
    assign dec_cnt   = trail_q ? rem_zero : rem;
    assign out_data  = !is_run ? '0 : (trail_q ? ~dec_therm : dec_therm);

    always_ff @(posedge clk) begin
        if (rst) begin
            trail_q  <= 1'b0;
            rem_zero <= '0;
        end else if (accept) begin
            trail_q  <= in_trail;
            rem_zero <= L_CNT - {1'b0, in_data};
        end else if (xfer) begin
            rem_zero <= rem_zero - zero_step;
        end
    end
`else
    assign dec_cnt  = rem;
    assign out_data = is_run ? dec_therm : '0;
`endif

    ung_thermo_dec #(
        .W (W),
        .P (P)
    ) u_dec (
        .cnt   (dec_cnt),
        .therm (dec_therm)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rem   <= '0;
            beat  <= '0;
        end else if (accept) begin
            // Covers the zero-bubble case: accepting on the last-beat transfer
            // reloads the counters and remains in RUN.
            state <= RUN;
            rem   <= {1'b0, in_data};
            beat  <= '0;
        end else if (xfer) begin
            rem  <= rem - rem_step;
            beat <= beat + 1'b1;
            if (out_last) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_ung_par_stream.sv
module tb_ung_par_stream;

    logic clk;
    logic rst;

    int n_vec;
    int n_miss;

    // a: W=4 P=4
    logic       a_iv, a_ir, a_ov, a_or, a_last;
    logic [3:0] a_d, a_q;
    // b: W=4 P=2
    logic       b_iv, b_ir, b_ov, b_or, b_last;
    logic [3:0] b_d;
    logic [1:0] b_q;
    // c: W=8 P=4
    logic       c_iv, c_ir, c_ov, c_or, c_last;
    logic [7:0] c_d;
    logic [3:0] c_q;
    // d: W=4 P=16
    logic        d_iv, d_ir, d_ov, d_or, d_last;
    logic [3:0]  d_d;
    logic [15:0] d_q;

`ifdef UNG_TRAIL_EN
    logic a_tr;
    logic z_tr;
`endif

    ung_par_stream #(.W(4), .P(4)) u_a (
        .clk(clk), .rst(rst),
        .in_valid(a_iv), .in_ready(a_ir), .in_data(a_d),
`ifdef UNG_TRAIL_EN
        .in_trail(a_tr),
`endif
        .out_valid(a_ov), .out_ready(a_or), .out_data(a_q), .out_last(a_last)
    );

    ung_par_stream #(.W(4), .P(2)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(b_iv), .in_ready(b_ir), .in_data(b_d),
`ifdef UNG_TRAIL_EN
        .in_trail(z_tr),
`endif
        .out_valid(b_ov), .out_ready(b_or), .out_data(b_q), .out_last(b_last)
    );

    ung_par_stream #(.W(8), .P(4)) u_c (
        .clk(clk), .rst(rst),
        .in_valid(c_iv), .in_ready(c_ir), .in_data(c_d),
`ifdef UNG_TRAIL_EN
        .in_trail(z_tr),
`endif
        .out_valid(c_ov), .out_ready(c_or), .out_data(c_q), .out_last(c_last)
    );

    ung_par_stream #(.W(4), .P(16)) u_d (
        .clk(clk), .rst(rst),
        .in_valid(d_iv), .in_ready(d_ir), .in_data(d_d),
`ifdef UNG_TRAIL_EN
        .in_trail(z_tr),
`endif
        .out_valid(d_ov), .out_ready(d_or), .out_data(d_q), .out_last(d_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One stream on instance a with out_ready held high; exp packs beat k in
    // bits [4k+3:4k].
    task automatic run_a(input string tag, input logic [3:0] n, input logic trail,
                         input logic [15:0] exp);
        @(negedge clk);
        a_iv = 1'b1;
        a_d  = n;
        a_or = 1'b1;
`ifdef UNG_TRAIL_EN
        a_tr = trail;
`else
        if (trail) $display("note: trail requested without UNG_TRAIL_EN");
`endif
        #1;
        chk({tag, " acc_ready"}, 32'(a_ir), 32'd1);
        chk({tag, " acc_valid"}, 32'(a_ov), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            a_iv = 1'b0;
            #1;
            chk($sformatf("%s valid%0d", tag, k), 32'(a_ov), 32'd1);
            chk($sformatf("%s data%0d", tag, k), 32'(a_q), 32'(exp[4*k +: 4]));
            chk($sformatf("%s last%0d", tag, k), 32'(a_last), 32'(k == 3));
            chk($sformatf("%s ready%0d", tag, k), 32'(a_ir), 32'(k == 3));
        end
        @(negedge clk);
        #1;
        chk({tag, " idle_valid"}, 32'(a_ov), 32'd0);
        chk({tag, " idle_data"}, 32'(a_q), 32'd0);
        chk({tag, " idle_last"}, 32'(a_last), 32'd0);
    endtask

    initial begin
        int         kb;
        int         pop;
        logic [15:0] exp2;
        logic [15:0] exp3;

        n_vec  = 0;
        n_miss = 0;
        rst  = 1'b1;
        a_iv = 0; a_d = 0; a_or = 0;
        b_iv = 0; b_d = 0; b_or = 0;
        c_iv = 0; c_d = 0; c_or = 0;
        d_iv = 0; d_d = 0; d_or = 0;
`ifdef UNG_TRAIL_EN
        a_tr = 0;
        z_tr = 0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst a_valid", 32'(a_ov), 32'd0);
        chk("rst a_last", 32'(a_last), 32'd0);
        chk("rst a_data", 32'(a_q), 32'd0);
        chk("rst a_ready", 32'(a_ir), 32'd1);
        chk("rst b_ready", 32'(b_ir), 32'd1);
        chk("rst c_ready", 32'(c_ir), 32'd1);
        chk("rst d_valid", 32'(d_ov), 32'd0);

        // N=6: 1111, 0011, 0000, 0000
        run_a("n6", 4'd6, 1'b0, 16'h003F);

        // N=0 then N=15 back-to-back with in_valid held
        exp2 = 16'h7FFF;
        @(negedge clk);
        a_iv = 1'b1; a_d = 4'd0; a_or = 1'b1;
        #1;
        chk("b2b acc_ready", 32'(a_ir), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            a_d = 4'd15;
            #1;
            chk($sformatf("b2b z_valid%0d", k), 32'(a_ov), 32'd1);
            chk($sformatf("b2b z_data%0d", k), 32'(a_q), 32'd0);
            chk($sformatf("b2b z_last%0d", k), 32'(a_last), 32'(k == 3));
            chk($sformatf("b2b z_ready%0d", k), 32'(a_ir), 32'(k == 3));
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            a_iv = 1'b0;
            #1;
            chk($sformatf("b2b f_valid%0d", k), 32'(a_ov), 32'd1);
            chk($sformatf("b2b f_data%0d", k), 32'(a_q), 32'(exp2[4*k +: 4]));
            chk($sformatf("b2b f_last%0d", k), 32'(a_last), 32'(k == 3));
        end
        @(negedge clk);
        #1;
        chk("b2b idle_valid", 32'(a_ov), 32'd0);

        // W=4 P=2, N=5 with out_ready pattern 1,0,0,1
        exp3 = 16'h001F;
        @(negedge clk);
        b_iv = 1'b1; b_d = 4'd5; b_or = 1'b0;
        #1;
        chk("p2 acc_ready", 32'(b_ir), 32'd1);
        kb  = 0;
        pop = 0;
        for (int c = 0; c < 40 && kb < 8; c++) begin
            @(negedge clk);
            b_iv = 1'b0;
            b_or = ((c % 4) == 0) || ((c % 4) == 3);
            #1;
            chk($sformatf("p2 valid c%0d", c), 32'(b_ov), 32'd1);
            chk($sformatf("p2 data c%0d", c), 32'(b_q), 32'(exp3[2*kb +: 2]));
            chk($sformatf("p2 last c%0d", c), 32'(b_last), 32'(kb == 7));
            if (b_or) begin
                pop = pop + $countones(b_q);
                kb++;
            end
        end
        chk("p2 beats", 32'(kb), 32'd8);
        chk("p2 popcount", 32'(pop), 32'd5);
        @(negedge clk);
        b_or = 1'b0;
        #1;
        chk("p2 idle_valid", 32'(b_ov), 32'd0);

        // W=8 P=4, N=200, reset on beat 10
        @(negedge clk);
        c_iv = 1'b1; c_d = 8'd200; c_or = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            c_iv = 1'b0;
            if (k == 10) rst = 1'b1;
            #1;
            chk($sformatf("w8 data%0d", k), 32'(c_q), 32'hF);
            chk($sformatf("w8 last%0d", k), 32'(c_last), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("w8 rst_valid", 32'(c_ov), 32'd0);
        chk("w8 rst_ready", 32'(c_ir), 32'd1);
        chk("w8 rst_last", 32'(c_last), 32'd0);
        c_iv = 1'b1; c_d = 8'd3;
        @(negedge clk);
        c_iv = 1'b0;
        #1;
        chk("w8 n3_valid", 32'(c_ov), 32'd1);
        chk("w8 n3_data", 32'(c_q), 32'h7);
        chk("w8 n3_last", 32'(c_last), 32'd0);
        c_or = 1'b0;

        // W=4 P=16, N=9: single beat
        @(negedge clk);
        d_iv = 1'b1; d_d = 4'd9; d_or = 1'b1;
        @(negedge clk);
        d_iv = 1'b0;
        #1;
        chk("p16 valid", 32'(d_ov), 32'd1);
        chk("p16 data", 32'(d_q), 32'h01FF);
        chk("p16 last", 32'(d_last), 32'd1);
        chk("p16 ready", 32'(d_ir), 32'd1);
        @(negedge clk);
        #1;
        chk("p16 idle_valid", 32'(d_ov), 32'd0);

`ifdef UNG_TRAIL_EN
        run_a("tr1", 4'd6, 1'b1, 16'hFC00);
        run_a("tr0", 4'd6, 1'b0, 16'h003F);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
